bot_app_if: RTL and testbench

BOT_APP_IF -- requirements
Module: bot_app_if

---
 rtl/bot_app_if.sv | 165 ++++++++++++++++
 tb/tb_bot_app_if.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bot_app_if.sv
// Purpose: application-CPU port window onto BOTSIM (snapshots, counters, motor/config regs, interrupt).
// Latency: read data registered, one clock after port_id; writes and events take effect at the next edge.
// Backpressure: none; strobes and events are accepted every cycle, overruns are counted instead of stalled.
module bot_app_if #(
  parameter logic [7:0] PORT_BASE  = 8'h00,
  parameter logic [7:0] BOTCFG_RST = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack,
  input  logic [7:0] LocX,
  input  logic [7:0] LocY,
  input  logic [7:0] Sensors,
  input  logic [7:0] BotInfo,
  input  logic [7:0] LMDist,
  input  logic [7:0] RMDist,
  input  logic       upd_sysregs,
  output logic [7:0] MotCtl,
  output logic [7:0] Bot_Config
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        upd_prev_q;
  logic [7:0]  snap_q [6];
  logic [7:0]  snap_d [6];
  logic [15:0] updcnt_q, updcnt_d;
  logic [7:0]  updhi_q, updhi_d;
  logic [7:0]  ovrcnt_q, ovrcnt_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  motctl_q, motctl_d;
  logic [7:0]  botcfg_q, botcfg_d;
  logic [7:0]  in_port_q, in_port_d;
  logic [7:0]  rd_dat;

  logic       hit;
  logic [3:0] off;
  logic       evt;
  logic       ovr_evt;
  logic       rd_status;
  logic       rd_lo;

  // Decode: only the upper nibble of PORT_BASE picks the window.
  assign hit       = (port_id[7:4] == PORT_BASE[7:4]);
  assign off       = port_id[3:0];
  // A held-high upd_sysregs is one event: compare against last cycle's level.
  assign evt       = upd_sysregs & ~upd_prev_q;
  // Overrun: a new event arrives while the previous one is still unacknowledged.
  assign ovr_evt   = evt & (state_q == PEND) & ~interrupt_ack;
  assign rd_status = hit & read_strobe & (off == 4'h6);
  assign rd_lo     = hit & read_strobe & (off == 4'h8);

  // FSM next state: a coincident event keeps the request pending despite an ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (evt) state_d = PEND;
      PEND:    if (interrupt_ack && !evt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read mux over current register contents; captured into in_port at the edge.
  always_comb begin
    rd_dat = 8'h00;
    case (off)
      4'h0:    rd_dat = snap_q[0];
      4'h1:    rd_dat = snap_q[1];
      4'h2:    rd_dat = snap_q[2];
      4'h3:    rd_dat = snap_q[3];
      4'h4:    rd_dat = snap_q[4];
      4'h5:    rd_dat = snap_q[5];
      4'h6:    rd_dat = {(state_q == PEND), ovr_q, 6'b0};
      4'h7:    rd_dat = ovrcnt_q;
      4'h8:    rd_dat = updcnt_q[7:0];
      4'h9:    rd_dat = updhi_q;
      4'hA:    rd_dat = motctl_q;
      4'hB:    rd_dat = botcfg_q;
      default: rd_dat = 8'h00;
    endcase
  end

  // Datapath next state: snapshots, counters, overrun status, CPU-written registers.
  always_comb begin
    snap_d    = snap_q;
    updcnt_d  = updcnt_q;
    updhi_d   = updhi_q;
    ovrcnt_d  = ovrcnt_q;
    ovr_d     = ovr_q;
    motctl_d  = motctl_q;
    botcfg_d  = botcfg_q;
    in_port_d = hit ? rd_dat : 8'h00;

    if (evt) begin
      snap_d[0] = LocX;
      snap_d[1] = LocY;
      snap_d[2] = Sensors;
      snap_d[3] = BotInfo;
      snap_d[4] = LMDist;
      snap_d[5] = RMDist;
      updcnt_d  = updcnt_q + 16'd1;
    end

    // A STATUS read clears overrun state, but a same-cycle overrun is not lost.
    if (rd_status) begin
      ovr_d    = ovr_evt;
      ovrcnt_d = ovr_evt ? 8'd1 : 8'd0;
    end else if (ovr_evt) begin
      ovr_d = 1'b1;
      if (ovrcnt_q != 8'hFF) ovrcnt_d = ovrcnt_q + 8'd1;
    end

    // Reading the low byte freezes the high byte so a lo-then-hi pair is coherent.
    if (rd_lo) updhi_d = updcnt_q[15:8];

    if (hit && write_strobe) begin
      if (off == 4'h0) motctl_d = out_port;
      if (off == 4'h1) botcfg_d = out_port;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_prev_q <= 1'b0;
      snap_q     <= '{default: 8'h00};
      updcnt_q   <= 16'h0000;
      updhi_q    <= 8'h00;
      ovrcnt_q   <= 8'h00;
      ovr_q      <= 1'b0;
      motctl_q   <= 8'h00;
      botcfg_q   <= BOTCFG_RST;
      in_port_q  <= 8'h00;
    end else begin
      upd_prev_q <= upd_sysregs;
      snap_q     <= snap_d;
      updcnt_q   <= updcnt_d;
      updhi_q    <= updhi_d;
      ovrcnt_q   <= ovrcnt_d;
      ovr_q      <= ovr_d;
      motctl_q   <= motctl_d;
      botcfg_q   <= botcfg_d;
      in_port_q  <= in_port_d;
    end
  end

  assign interrupt  = (state_q == PEND);
  assign in_port    = in_port_q;
  assign MotCtl     = motctl_q;
  assign Bot_Config = botcfg_q;

endmodule

// File: tb/tb_bot_app_if.sv
// Purpose: randomized plus directed stimulus for bot_app_if against a queue-based reference model.
// Latency: expectations are pushed per stimulus cycle and popped one clock later by the monitor.
// Backpressure: none; the monitor consumes one expectation per clock.
module tb_bot_app_if;

  localparam logic [7:0] BASE = 8'h07;
  localparam logic [7:0] CFGR = 8'h5A;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_id, out_port, in_port;
  logic       write_strobe, read_strobe, interrupt, interrupt_ack, upd_sysregs;
  logic [7:0] LocX, LocY, Sensors, BotInfo, LMDist, RMDist, MotCtl, Bot_Config;

  always #5 clk = ~clk;

  bot_app_if #(.PORT_BASE(BASE), .BOTCFG_RST(CFGR)) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .out_port(out_port), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack),
    .LocX(LocX), .LocY(LocY), .Sensors(Sensors), .BotInfo(BotInfo),
    .LMDist(LMDist), .RMDist(RMDist), .upd_sysregs(upd_sysregs),
    .MotCtl(MotCtl), .Bot_Config(Bot_Config)
  );

  typedef struct packed {
    logic [7:0] inp;
    logic       irq;
    logic [7:0] mot;
    logic [7:0] cfg;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state, kept as plain values.
  logic [7:0] m_snap [6];
  logic       m_pend, m_ovr, m_prev;
  int         m_ovrcnt, m_cnt;
  logic [7:0] m_hi, m_mot, m_cfg;
  logic [7:0] sys [6];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_snap[i] = 8'h00;
    m_pend = 0; m_ovr = 0; m_prev = 0;
    m_ovrcnt = 0; m_cnt = 0;
    m_hi = 8'h00; m_mot = 8'h00; m_cfg = CFGR;
  endtask

  function automatic logic [7:0] m_read(input logic [3:0] off);
    logic [15:0] c;
    c = m_cnt[15:0];
    case (off)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: return m_snap[int'(off)];
      4'h6: return {m_pend, m_ovr, 6'b0};
      4'h7: return m_ovrcnt[7:0];
      4'h8: return c[7:0];
      4'h9: return m_hi;
      4'hA: return m_mot;
      4'hB: return m_cfg;
      default: return 8'h00;
    endcase
  endfunction

  // One stimulus cycle: apply inputs at the falling edge, step the model, queue the expectation.
  task automatic drive(input logic [7:0] pid, input logic ws, input logic rs,
                       input logic [7:0] od, input logic ack, input logic upd);
    exp_t       e;
    logic       hit, ev, ovr;
    logic [3:0] off;
    logic [15:0] c;
    @(negedge clk);
    port_id = pid; write_strobe = ws; read_strobe = rs; out_port = od;
    interrupt_ack = ack; upd_sysregs = upd;
    LocX = sys[0]; LocY = sys[1]; Sensors = sys[2];
    BotInfo = sys[3]; LMDist = sys[4]; RMDist = sys[5];

    hit   = (pid[7:4] == BASE[7:4]);
    off   = pid[3:0];
    e.inp = hit ? m_read(off) : 8'h00;
    ev    = upd && !m_prev;
    ovr   = ev && m_pend && !ack;
    c     = m_cnt[15:0];
    if (hit && rs && off == 4'h8) m_hi = c[15:8];
    if (hit && rs && off == 4'h6) begin
      m_ovr    = ovr;
      m_ovrcnt = ovr ? 1 : 0;
    end else if (ovr) begin
      m_ovr    = 1;
      m_ovrcnt = (m_ovrcnt < 255) ? m_ovrcnt + 1 : 255;
    end
    if (ev) begin
      for (int i = 0; i < 6; i++) m_snap[i] = sys[i];
      m_cnt = (m_cnt + 1) % 65536;
    end
    if (ev)       m_pend = 1;
    else if (ack) m_pend = 0;
    if (hit && ws && off == 4'h0) m_mot = od;
    if (hit && ws && off == 4'h1) m_cfg = od;
    m_prev = upd;

    e.irq = m_pend;
    e.mot = m_mot;
    e.cfg = m_cfg;
    sb.push_back(e);
  endtask

  // Monitor: after each rising edge, compare the DUT with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check8("in_port",    in_port,              e.inp);
        check8("interrupt",  {7'b0, interrupt},    {7'b0, e.irq});
        check8("MotCtl",     MotCtl,               e.mot);
        check8("Bot_Config", Bot_Config,           e.cfg);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    if (sb.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic idle_inputs(input logic upd);
    port_id = 8'hF0; write_strobe = 0; read_strobe = 0; out_port = 8'h00;
    interrupt_ack = 0; upd_sysregs = upd;
  endtask

  // Asynchronous reset mid-cycle with immediate checks, then release between edges.
  task automatic do_reset(input logic upd_at_release);
    drain();
    @(posedge clk); #2;
    idle_inputs(1'b0);
    reset = 0;
    #1;
    check8("rst_interrupt",  {7'b0, interrupt}, 8'h00);
    check8("rst_MotCtl",     MotCtl,            8'h00);
    check8("rst_Bot_Config", Bot_Config,        CFGR);
    check8("rst_in_port",    in_port,           8'h00);
    repeat (2) @(posedge clk);
    #2;
    upd_sysregs = upd_at_release;
    model_reset();
    reset = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 6; i++) sys[i] = 8'h00;
    idle_inputs(1'b0);
    LocX = 0; LocY = 0; Sensors = 0; BotInfo = 0; LMDist = 0; RMDist = 0;
    reset = 0;
    model_reset();
    #12;
    check8("init_interrupt",  {7'b0, interrupt}, 8'h00);
    check8("init_in_port",    in_port,           8'h00);
    check8("init_MotCtl",     MotCtl,            8'h00);
    check8("init_Bot_Config", Bot_Config,        CFGR);
    @(posedge clk); #2;
    reset = 1;

    // First event, snapshot readback, UPDCNT = 1.
    sys[0] = 8'h12; sys[1] = 8'h34; sys[2] = 8'h56;
    drive(8'hF0, 0, 0, 8'h00, 0, 0);
    drive(8'hF0, 0, 0, 8'h00, 0, 1);
    drive(8'h00, 0, 0, 8'h00, 0, 1);
    drive(8'h01, 0, 0, 8'h00, 0, 1);
    drive(8'h08, 0, 0, 8'h00, 0, 1);
    drive(8'h09, 0, 0, 8'h00, 0, 1);

    // Ack alone clears; ack with a coincident event keeps pending, no overrun.
    drive(8'h06, 0, 0, 8'h00, 1, 1);
    drive(8'h06, 0, 0, 8'h00, 0, 0);
    drive(8'h06, 0, 0, 8'h00, 0, 1);
    drive(8'h06, 0, 0, 8'h00, 0, 0);
    drive(8'h07, 0, 0, 8'h00, 1, 1);
    drive(8'h06, 0, 0, 8'h00, 0, 0);
    drive(8'h07, 0, 0, 8'h00, 1, 0);
    drive(8'h06, 0, 0, 8'h00, 1, 0);

    // Three events without ack, then a clearing STATUS read.
    for (int k = 0; k < 3; k++) begin
      drive(8'h06, 0, 0, 8'h00, 0, 1);
      drive(8'h07, 0, 0, 8'h00, 0, 0);
    end
    drive(8'h06, 0, 1, 8'h00, 0, 0);
    drive(8'h06, 0, 0, 8'h00, 0, 0);
    drive(8'h07, 0, 0, 8'h00, 0, 0);
    // STATUS read colliding with an overrun event.
    drive(8'h06, 0, 1, 8'h00, 0, 1);
    drive(8'h07, 0, 0, 8'h00, 0, 0);
    drive(8'h06, 0, 0, 8'h00, 0, 0);

    // UPDCNT hi-byte latch across a carry.
    do_reset(1'b0);
    while (m_cnt != 255) begin
      drive(8'hF0, 0, 0, 8'h00, 1, 1);
      drive(8'hF0, 0, 0, 8'h00, 1, 0);
    end
    drive(8'h08, 0, 1, 8'h00, 0, 0);
    drive(8'hF0, 0, 0, 8'h00, 0, 1);
    drive(8'h09, 0, 1, 8'h00, 0, 0);
    drive(8'h08, 0, 0, 8'h00, 0, 0);
    drive(8'h09, 0, 0, 8'h00, 0, 0);

    // Register writes, readback, ignored offset, writes during an event.
    drive(8'h00, 1, 0, 8'hA5, 0, 0);
    drive(8'h01, 1, 0, 8'h3C, 0, 0);
    drive(8'h0A, 0, 0, 8'h00, 0, 0);
    drive(8'h0B, 0, 0, 8'h00, 0, 0);
    drive(8'h05, 1, 0, 8'h77, 0, 0);
    drive(8'h0A, 0, 0, 8'h00, 0, 1);
    drive(8'h00, 1, 0, 8'hC3, 0, 0);
    drive(8'h10, 1, 0, 8'h99, 0, 0);
    drive(8'h0A, 0, 0, 8'h00, 0, 0);
    // Reset while pending: interrupt and registers drop asynchronously.
    do_reset(1'b0);

    // Randomized traffic.
    for (int k = 0; k < 800; k++) begin
      logic [7:0] pid;
      for (int i = 0; i < 6; i++) sys[i] = 8'($urandom);
      pid = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
      drive(pid, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            8'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    // upd_sysregs already high at reset release gives exactly one event.
    do_reset(1'b1);
    drive(8'h08, 0, 0, 8'h00, 0, 1);
    drive(8'h08, 0, 0, 8'h00, 0, 1);
    drive(8'h06, 0, 0, 8'h00, 0, 0);

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
